// File: rtl/correlator_host_ctrl_pkg.sv
// Shared definitions for the correlator host controller: register map,
// control-register bit positions, RX/TX state encodings and helpers.
package correlator_host_ctrl_pkg;

    // Bytes per correlator packet: window number plus four count bytes
    localparam int PKT_LEN_DEFAULT = 5;

    // Register addresses (7-bit address field of the command byte)
    localparam logic [6:0] ADDR_SEED       = 7'd0;
    localparam logic [6:0] ADDR_WIN_LEN    = 7'd1;
    localparam logic [6:0] ADDR_WIN_SHAPE  = 7'd2;
    localparam logic [6:0] ADDR_PERIOD     = 7'd3;
    localparam logic [6:0] ADDR_JITTER     = 7'd4;
    localparam logic [6:0] ADDR_LED        = 7'd5;
    localparam logic [6:0] ADDR_CTRL       = 7'd6;

    // Control register bit positions
    localparam int CTRL_STREAM_EN_BIT = 0;
    localparam int CTRL_FLUSH_BIT     = 1;

    // Command parser states
    typedef enum logic {
        RX_CMD  = 1'b0,
        RX_DATA = 1'b1
    } rx_state_t;

    // TX path states
    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_STREAM = 2'd1,
        TX_RESP   = 2'd2
    } tx_state_t;

    // Clamp an unsigned byte to an upper limit
    function automatic logic [7:0] sat_u8(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value > limit) begin
            result = limit;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/correlator_host_ctrl_tx_byte_arbiter.sv
// TX byte arbiter: owns the TX holding register, the in-packet byte index,
// the TX state machine and the FIFO pop/flush timing. Read responses only
// go out on packet boundaries so a 5-byte packet is never split.
module tx_byte_arbiter
    import correlator_host_ctrl_pkg::*;
#(
    parameter int PKT_LEN = PKT_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cg,
    input  logic       stream_en,
    input  logic       resp_req,
    input  logic [7:0] resp_data,
    output logic       resp_take,
    input  logic       flush_req,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       fifo_flush,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    tx_state_t        tx_state_r;
    logic [7:0]       tx_byte_r;
    logic             tx_valid_r;
    logic [IDX_W-1:0] idx_r;
    logic             flush_pend_r;
    logic             flush_r;

    logic tx_free_s;
    logic at_boundary_s;
    logic flush_block_s;
    logic load_resp_s;
    logic load_stream_s;
    logic flush_fire_s;

    assign tx_free_s     = !tx_valid_r || tx_ready;
    assign at_boundary_s = (idx_r == '0);
    // Stream loads stay off the boundary from the moment a flush is pending
    // until the flush pulse has been seen by the FIFO
    assign flush_block_s = flush_pend_r || flush_r;

    // Choose what (if anything) enters the TX holding register this cycle
    always_comb begin
        load_resp_s   = 1'b0;
        load_stream_s = 1'b0;
        if (cg && tx_free_s) begin
            if (!at_boundary_s) begin
                // Mid-packet: only the packet may continue, even if streamEn dropped
                load_stream_s = !fifo_empty;
            end else if (resp_req) begin
                load_resp_s = 1'b1;
            end else if (stream_en && !fifo_empty && !flush_block_s) begin
                load_stream_s = 1'b1;
            end else begin
                load_stream_s = 1'b0;
            end
        end else begin
            load_resp_s   = 1'b0;
            load_stream_s = 1'b0;
        end
    end

    assign flush_fire_s = cg && flush_pend_r && at_boundary_s && !load_stream_s;

    // TX state machine, holding register, byte index and flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r   <= TX_IDLE;
            tx_byte_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            idx_r        <= '0;
            flush_pend_r <= 1'b0;
            flush_r      <= 1'b0;
        end else if (cg) begin
            if (load_resp_s) begin
                tx_byte_r  <= resp_data;
                tx_valid_r <= 1'b1;
                tx_state_r <= TX_RESP;
            end else if (load_stream_s) begin
                tx_byte_r  <= fifo_data;
                tx_valid_r <= 1'b1;
                tx_state_r <= TX_STREAM;
                idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
            end else begin
                if (tx_ready) begin
                    tx_valid_r <= 1'b0;
                end else begin
                    tx_valid_r <= tx_valid_r;
                end
                if (tx_free_s) begin
                    tx_state_r <= at_boundary_s ? TX_IDLE : TX_STREAM;
                end else begin
                    tx_state_r <= tx_state_r;
                end
            end
            flush_r      <= flush_fire_s;
            flush_pend_r <= (flush_pend_r || flush_req) && !flush_fire_s;
        end else begin
            // Clock gate low: state holds, strobes do not stretch
            flush_r <= 1'b0;
        end
    end

    // The pop must coincide with the load so the FIFO head advances at the same edge
    assign fifo_pop   = load_stream_s;
    assign resp_take  = load_resp_s;
    assign fifo_flush = flush_r;
    assign tx_byte    = tx_byte_r;
    assign tx_valid   = tx_valid_r;

endmodule

// File: rtl/correlator_host_ctrl.sv
// Host-side controller for the correlator: parses 2-byte register commands
// from the host link, holds the correlator configuration registers and
// hands read responses and packet bytes to the TX arbiter.
module correlator_host_ctrl
    import correlator_host_ctrl_pkg::*;
#(
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int MAX_SAMPLE_JITTER_EXP = 8,
    parameter int PKT_LEN               = PKT_LEN_DEFAULT,
    parameter int RST_WINDOW_LENGTH_EXP = 10,
    parameter int RST_SAMPLE_PERIOD_EXP = 0,
    localparam int WLEN_W   = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
    localparam int PERIOD_W = $clog2(MAX_SAMPLE_PERIOD_EXP + 1),
    localparam int JITTER_W = $clog2(MAX_SAMPLE_JITTER_EXP + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cg,
    input  logic [7:0]          i_rxByte,
    input  logic                i_rxValid,
    output logic                o_rxReady,
    output logic [7:0]          o_txByte,
    output logic                o_txValid,
    input  logic                i_txReady,
    input  logic [7:0]          i_pktfifo_data,
    input  logic                i_pktfifo_empty,
    output logic                o_pktfifo_pop,
    output logic                o_pktfifo_flush,
    output logic [WLEN_W-1:0]   o_windowLengthExp,
    output logic                o_windowShape,
    output logic [PERIOD_W-1:0] o_samplePeriodExp,
    output logic [JITTER_W-1:0] o_sampleJitterExp,
    output logic [2:0]          o_ledSource,
    output logic [7:0]          o_jitterSeedByte,
    output logic                o_jitterSeedValid
);

    rx_state_t  rx_state_r;
    logic [6:0] wr_addr_r;
    logic       resp_pend_r;
    logic [7:0] resp_byte_r;
    logic       rx_ready_r;
    logic       stream_en_r;

    logic       rx_accept_s;
    logic       rd_accept_s;
    logic       wr_accept_s;
    logic       wr_flush_s;
    logic [7:0] rd_data_s;
    logic       resp_req_s;
    logic [7:0] resp_data_s;
    logic       resp_take_s;
    logic       resp_pend_next_s;

    assign rx_accept_s = i_cg && i_rxValid && rx_ready_r;
    assign rd_accept_s = rx_accept_s && (rx_state_r == RX_CMD) && i_rxByte[7];
    assign wr_accept_s = rx_accept_s && (rx_state_r == RX_DATA);
    assign wr_flush_s  = wr_accept_s && (wr_addr_r == ADDR_CTRL) && i_rxByte[CTRL_FLUSH_BIT];

    // Read-back value for the address carried in the current command byte
    always_comb begin
        rd_data_s = 8'h00;
        case (i_rxByte[6:0])
            ADDR_WIN_LEN:   rd_data_s = 8'(o_windowLengthExp);
            ADDR_WIN_SHAPE: rd_data_s = {7'b0000000, o_windowShape};
            ADDR_PERIOD:    rd_data_s = 8'(o_samplePeriodExp);
            ADDR_JITTER:    rd_data_s = 8'(o_sampleJitterExp);
            ADDR_LED:       rd_data_s = {5'b00000, o_ledSource};
            ADDR_CTRL:      rd_data_s = {7'b0000000, stream_en_r};
            default:        rd_data_s = 8'h00;
        endcase
    end

    // A read offered in its accept cycle can be loaded straight away when TX is free
    assign resp_req_s       = resp_pend_r || rd_accept_s;
    assign resp_data_s      = resp_pend_r ? resp_byte_r : rd_data_s;
    assign resp_pend_next_s = resp_req_s && !resp_take_s;

    // Command parser FSM and single outstanding read tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_r  <= RX_CMD;
            wr_addr_r   <= 7'd0;
            resp_pend_r <= 1'b0;
            resp_byte_r <= 8'h00;
            rx_ready_r  <= 1'b1;
        end else if (i_cg) begin
            case (rx_state_r)
                RX_CMD: begin
                    if (rx_accept_s && !i_rxByte[7]) begin
                        wr_addr_r  <= i_rxByte[6:0];
                        rx_state_r <= RX_DATA;
                    end else begin
                        rx_state_r <= RX_CMD;
                    end
                end
                RX_DATA: begin
                    if (rx_accept_s) begin
                        rx_state_r <= RX_CMD;
                    end else begin
                        rx_state_r <= RX_DATA;
                    end
                end
                default: rx_state_r <= RX_CMD;
            endcase
            if (rd_accept_s) begin
                resp_byte_r <= rd_data_s;
            end else begin
                resp_byte_r <= resp_byte_r;
            end
            resp_pend_r <= resp_pend_next_s;
            rx_ready_r  <= !resp_pend_next_s;
        end else begin
            rx_state_r <= rx_state_r;
        end
    end

    // Configuration registers and the seed strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_windowLengthExp <= WLEN_W'(RST_WINDOW_LENGTH_EXP);
            o_windowShape     <= 1'b0;
            o_samplePeriodExp <= PERIOD_W'(RST_SAMPLE_PERIOD_EXP);
            o_sampleJitterExp <= '0;
            o_ledSource       <= 3'd0;
            o_jitterSeedByte  <= 8'h00;
            o_jitterSeedValid <= 1'b0;
            stream_en_r       <= 1'b0;
        end else if (i_cg) begin
            o_jitterSeedValid <= wr_accept_s && (wr_addr_r == ADDR_SEED);
            if (wr_accept_s) begin
                case (wr_addr_r)
                    ADDR_SEED:      o_jitterSeedByte  <= i_rxByte;
                    ADDR_WIN_LEN:   o_windowLengthExp <= WLEN_W'(sat_u8(i_rxByte, 8'(MAX_WINDOW_LENGTH_EXP)));
                    ADDR_WIN_SHAPE: o_windowShape     <= i_rxByte[0];
                    ADDR_PERIOD:    o_samplePeriodExp <= PERIOD_W'(sat_u8(i_rxByte, 8'(MAX_SAMPLE_PERIOD_EXP)));
                    ADDR_JITTER:    o_sampleJitterExp <= JITTER_W'(sat_u8(i_rxByte, 8'(MAX_SAMPLE_JITTER_EXP)));
                    ADDR_LED:       o_ledSource       <= i_rxByte[2:0];
                    ADDR_CTRL:      stream_en_r       <= i_rxByte[CTRL_STREAM_EN_BIT];
                    default:        stream_en_r       <= stream_en_r;
                endcase
            end else begin
                stream_en_r <= stream_en_r;
            end
        end else begin
            o_jitterSeedValid <= 1'b0;
        end
    end

    assign o_rxReady = rx_ready_r;

    tx_byte_arbiter #(
        .PKT_LEN (PKT_LEN)
    ) u_tx_arb (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .cg         (i_cg),
        .stream_en  (stream_en_r),
        .resp_req   (resp_req_s),
        .resp_data  (resp_data_s),
        .resp_take  (resp_take_s),
        .flush_req  (wr_flush_s),
        .fifo_data  (i_pktfifo_data),
        .fifo_empty (i_pktfifo_empty),
        .fifo_pop   (o_pktfifo_pop),
        .fifo_flush (o_pktfifo_flush),
        .tx_byte    (o_txByte),
        .tx_valid   (o_txValid),
        .tx_ready   (i_txReady)
    );

endmodule

// File: tb/tb_correlator_host_ctrl.sv
// Directed bench for correlator_host_ctrl with a packet FIFO model and a
// host-side receive log.
module tb_correlator_host_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cg;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       fifo_flush;
    logic [4:0] win_len;
    logic       win_shape;
    logic [3:0] period;
    logic [3:0] jitter;
    logic [2:0] led;
    logic [7:0] seed_byte;
    logic       seed_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] log_q[$];
    int         cyc_q[$];
    int         cyc = 0;
    int         pop_cnt = 0;
    int         flush_cnt = 0;
    int         both_cnt = 0;
    logic       pop_c = 1'b0;
    logic       flush_c = 1'b0;

    correlator_host_ctrl dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cg              (cg),
        .i_rxByte          (rx_byte),
        .i_rxValid         (rx_valid),
        .o_rxReady         (rx_ready),
        .o_txByte          (tx_byte),
        .o_txValid         (tx_valid),
        .i_txReady         (tx_ready),
        .i_pktfifo_data    (fifo_data),
        .i_pktfifo_empty   (fifo_empty),
        .o_pktfifo_pop     (fifo_pop),
        .o_pktfifo_flush   (fifo_flush),
        .o_windowLengthExp (win_len),
        .o_windowShape     (win_shape),
        .o_samplePeriodExp (period),
        .o_sampleJitterExp (jitter),
        .o_ledSource       (led),
        .o_jitterSeedByte  (seed_byte),
        .o_jitterSeedValid (seed_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void fifo_refresh();
        if (fifo_q.size() > 0) begin
            fifo_data  = fifo_q[0];
            fifo_empty = 1'b0;
        end else begin
            fifo_data  = 8'h00;
            fifo_empty = 1'b1;
        end
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_refresh();
    endtask

    // Mid-cycle observation of FIFO strobes and host-side transfers
    always @(negedge clk) begin
        cyc++;
        pop_c   = fifo_pop;
        flush_c = fifo_flush;
        if (fifo_pop)  pop_cnt++;
        if (fifo_flush) flush_cnt++;
        if (fifo_pop && fifo_flush) both_cnt++;
        if (tx_valid && tx_ready) begin
            log_q.push_back(tx_byte);
            cyc_q.push_back(cyc);
        end
    end

    // FIFO model: apply the strobes seen in the cycle that just ended
    always @(posedge clk) begin
        #1;
        if (flush_c) begin
            fifo_q.delete();
        end else if (pop_c && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        pop_c   = 1'b0;
        flush_c = 1'b0;
        fifo_refresh();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        int   k;
        logic ok;
        rx_byte  = b;
        rx_valid = 1'b1;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 200) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            ok = rdy;
            k++;
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("log_count", 32'(log_q.size()), 32'(n));
    endtask

    task automatic check_reset_outputs();
        check("rst_txValid", 32'(tx_valid), 32'd0);
        check("rst_rxReady", 32'(rx_ready), 32'd1);
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_flush", 32'(fifo_flush), 32'd0);
        check("rst_seedValid", 32'(seed_valid), 32'd0);
        check("rst_txByte", 32'(tx_byte), 32'd0);
        check("rst_winLen", 32'(win_len), 32'd10);
        check("rst_shape", 32'(win_shape), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_jitter", 32'(jitter), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_seedByte", 32'(seed_byte), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pop_base;
        int   flush_base;
        int   both_base;
        logic [7:0] snap;
        logic stable;
        logic [7:0] exp_rd[5];

        rst_n = 1'b0; cg = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        fifo_refresh();
        tick(3);
        check_reset_outputs();
        rst_n = 1'b1;
        tick(2);

        // Saturating write, then read-back latency
        send(8'h01);
        check("winLen_before_data", 32'(win_len), 32'd10);
        send(8'h14);
        check("winLen_sat", 32'(win_len), 32'd16);
        send(8'h81);
        check("rd_latency_valid", 32'(tx_valid), 32'd1);
        check("rd_latency_byte", 32'(tx_byte), 32'h10);
        tick(3);
        wait_log(1, 5);
        check("rd_winLen", 32'(log_q[0]), 32'h10);
        log_q.delete(); cyc_q.delete();

        // Seed strobe and other config registers
        send(8'h00); send(8'hA5);
        check("seed_byte", 32'(seed_byte), 32'hA5);
        check("seed_valid_hi", 32'(seed_valid), 32'd1);
        tick(1);
        check("seed_valid_lo", 32'(seed_valid), 32'd0);
        send(8'h03); send(8'hFF);
        send(8'h04); send(8'h20);
        send(8'h05); send(8'hFF);
        send(8'h02); send(8'h03);
        check("period_sat", 32'(period), 32'd15);
        check("jitter_sat", 32'(jitter), 32'd8);
        check("led_trunc", 32'(led), 32'd7);
        check("shape_bit0", 32'(win_shape), 32'd1);
        send(8'h83); send(8'h84); send(8'h85); send(8'h80); send(8'hFF);
        exp_rd[0] = 8'h0F; exp_rd[1] = 8'h08; exp_rd[2] = 8'h07; exp_rd[3] = 8'h00; exp_rd[4] = 8'h00;
        wait_log(5, 20);
        for (int i = 0; i < 5; i++) begin
            check("rd_cfg", 32'(log_q[i]), 32'(exp_rd[i]));
        end
        log_q.delete(); cyc_q.delete();

        // Continuous streaming of two packets
        pop_base = pop_cnt;
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
        send(8'h06); send(8'h01);
        wait_log(10, 100);
        for (int i = 0; i < 10; i++) begin
            check("stream_byte", 32'(log_q[i]), 32'(8'h30 + i));
        end
        check("stream_pops", 32'(pop_cnt - pop_base), 32'd10);
        check("stream_no_bubble", 32'(cyc_q[9] - cyc_q[0]), 32'd9);
        log_q.delete(); cyc_q.delete();

        // Read issued mid-packet waits for the packet end
        push(8'h40); push(8'h41);
        tick(8);
        check("mid_two_bytes", 32'(log_q.size()), 32'd2);
        send(8'h85);
        tick(1);
        check("mid_rxReady_lo", 32'(rx_ready), 32'd0);
        tick(8);
        check("mid_resp_held", 32'(log_q.size()), 32'd2);
        check("mid_rxReady_hold", 32'(rx_ready), 32'd0);
        push(8'h42); push(8'h43); push(8'h44);
        wait_log(6, 50);
        for (int i = 2; i < 5; i++) begin
            check("mid_pkt_byte", 32'(log_q[i]), 32'(8'h40 + i));
        end
        check("mid_resp_after_pkt", 32'(log_q[5]), 32'h07);
        tick(2);
        check("mid_rxReady_back", 32'(rx_ready), 32'd1);
        log_q.delete(); cyc_q.delete();

        // Flush written mid-packet takes effect at the packet boundary
        pop_base = pop_cnt; flush_base = flush_cnt; both_base = both_cnt;
        push(8'h50); push(8'h51);
        tick(8);
        send(8'h06); send(8'h03);
        for (int i = 2; i < 7; i++) push(8'(8'h50 + i));
        wait_log(5, 50);
        tick(10);
        check("flush_log_size", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("flush_pkt_byte", 32'(log_q[i]), 32'(8'h50 + i));
        end
        check("flush_once", 32'(flush_cnt - flush_base), 32'd1);
        check("flush_pops", 32'(pop_cnt - pop_base), 32'd5);
        check("flush_pop_overlap", 32'(both_cnt - both_base), 32'd0);
        check("flush_fifo_empty", 32'(fifo_q.size()), 32'd0);
        send(8'h86);
        wait_log(6, 20);
        check("flush_streamEn_kept", 32'(log_q[5]), 32'h01);
        log_q.delete(); cyc_q.delete();

        // Host stall mid-stream, then asynchronous reset mid-packet
        for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
        tick(2);
        tx_ready = 1'b0;
        tick(1);
        snap     = tx_byte;
        pop_base = pop_cnt;
        stable   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx_byte !== snap || tx_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_no_pop", 32'(pop_cnt - pop_base), 32'd0);
        check("stall_log_prefix", 32'(log_q[0]), 32'h60);
        tx_ready = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_idle", 32'(tx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
